// File: rtl/i2c_mem_arbiter_if.sv
// Requester-side handshake bundle shared by both ports of the I2C memory arbiter.
interface i2c_mem_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  rw;
  logic [13:0] addr;
  logic [15:0] wdata;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic        ack_err;
  logic        busy;

  modport master (output req, rw, addr, wdata, input done, rdata, ack_err, busy);
  modport slave  (input req, rw, addr, wdata, output done, rdata, ack_err, busy);
endinterface

// File: rtl/i2c_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-byte I2C memory master.
// Each bus bit is a slot of four quarters; outputs are registered from next-state values.
module i2c_mem_arbiter #(
  parameter int unsigned sys_freq = 40000000,
  parameter int unsigned i2c_freq = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  i2c_mem_arbiter_if.slave bus,
  output logic             scl,
  inout  wire              sda
);
  localparam int unsigned q_clks    = sys_freq / (4 * i2c_freq);
  localparam int unsigned slot_clks = 4 * q_clks;
  localparam int unsigned qcnt_w    = $clog2(slot_clks);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA, S_RDATA, S_DATA_ACK, S_STOP, S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [qcnt_w-1:0]   r_qcnt, w_qcnt_nxt;
  logic [2:0]          r_bcnt, w_bcnt_nxt;
  logic                r_ptr, w_ptr_nxt;
  logic                r_gidx, w_gidx_nxt;
  logic                r_rw, w_rw_nxt;
  logic [6:0]          r_addr, w_addr_nxt;
  logic [7:0]          r_wdata, w_wdata_nxt;
  logic [7:0]          r_shift, w_shift_nxt;
  logic                r_samp, w_samp_nxt;
  logic [1:0]          r_done, w_done_nxt;
  logic [7:0]          r_rdata, w_rdata_nxt;
  logic                r_ack_err, w_ack_err_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_scl, w_scl_nxt;
  logic                r_sda_rel, w_rel_nxt;

  logic                w_slot_end, w_sample, w_last_bit, w_q_hi, w_sda_in;
  logic [7:0]          w_addr_byte;

  // Open-drain pad: only ever pull low; a released line reads back as 1 via the pull-up
  assign sda        = r_sda_rel ? 1'bz : 1'b0;
  assign w_sda_in   = sda;
  assign scl        = r_scl;

  assign bus.done    = r_done;
  assign bus.rdata   = r_rdata;
  assign bus.ack_err = r_ack_err;
  assign bus.busy    = r_busy;

  assign w_slot_end  = (r_qcnt == qcnt_w'(slot_clks - 1));
  assign w_sample    = (r_qcnt == qcnt_w'(3 * q_clks - 1));
  assign w_last_bit  = (r_bcnt == 3'd7);
  assign w_addr_byte = {r_rw, r_addr};

  always_comb begin
    w_state_nxt   = r_state;
    w_qcnt_nxt    = r_qcnt;
    w_bcnt_nxt    = r_bcnt;
    w_ptr_nxt     = r_ptr;
    w_gidx_nxt    = r_gidx;
    w_rw_nxt      = r_rw;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_shift_nxt   = r_shift;
    w_samp_nxt    = r_samp;
    w_done_nxt    = 2'b00;
    w_rdata_nxt   = r_rdata;
    w_ack_err_nxt = r_ack_err;
    w_scl_nxt     = 1'b1;
    w_rel_nxt     = 1'b1;
    w_q_hi        = 1'b0;

    if (r_state != S_IDLE && r_state != S_DONE) begin
      w_qcnt_nxt = w_slot_end ? '0 : r_qcnt + qcnt_w'(1);
      if (w_sample) w_samp_nxt = w_sda_in;
      if (w_sample && r_state == S_RDATA) w_shift_nxt = {r_shift[6:0], w_sda_in};
    end

    case (r_state)
      S_IDLE: begin
        w_qcnt_nxt = '0;
        w_bcnt_nxt = 3'd0;
        if (bus.req != 2'b00) begin
          w_gidx_nxt    = (bus.req == 2'b11) ? r_ptr : bus.req[1];
          w_ptr_nxt     = ~w_gidx_nxt;
          w_rw_nxt      = bus.rw[w_gidx_nxt];
          w_addr_nxt    = w_gidx_nxt ? bus.addr[13:7] : bus.addr[6:0];
          w_wdata_nxt   = w_gidx_nxt ? bus.wdata[15:8] : bus.wdata[7:0];
          w_ack_err_nxt = 1'b0;
          w_state_nxt   = S_START;
        end
      end
      S_START: if (w_slot_end) w_state_nxt = S_ADDR;
      S_ADDR, S_WDATA, S_RDATA: begin
        if (w_slot_end) begin
          if (w_last_bit) begin
            w_bcnt_nxt  = 3'd0;
            w_state_nxt = (r_state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
          end else begin
            w_bcnt_nxt = r_bcnt + 3'd1;
          end
        end
      end
      S_ADDR_ACK: begin
        if (w_slot_end) begin
          if (r_samp) begin
            w_ack_err_nxt = 1'b1;
            w_state_nxt   = S_STOP;
          end else begin
            w_state_nxt = r_rw ? S_RDATA : S_WDATA;
          end
        end
      end
      S_DATA_ACK: begin
        if (w_slot_end) begin
          if (!r_rw && r_samp) w_ack_err_nxt = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // done and rdata are registered on entry so they are valid during the DONE cycle
        if (w_slot_end) begin
          w_state_nxt        = S_DONE;
          w_done_nxt[r_gidx] = 1'b1;
          if (r_rw && !r_ack_err) w_rdata_nxt = r_shift;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Pad levels for the cycle that the next state/quarter describe
    w_q_hi = (w_qcnt_nxt >= qcnt_w'(2 * q_clks));
    case (w_state_nxt)
      S_START: w_rel_nxt = !w_q_hi;
      S_ADDR: begin
        w_scl_nxt = w_q_hi;
        w_rel_nxt = w_addr_byte[3'd7 - w_bcnt_nxt];
      end
      S_WDATA: begin
        w_scl_nxt = w_q_hi;
        w_rel_nxt = r_wdata[3'd7 - w_bcnt_nxt];
      end
      S_ADDR_ACK, S_RDATA, S_DATA_ACK: w_scl_nxt = w_q_hi;
      S_STOP: begin
        w_scl_nxt = w_q_hi;
        w_rel_nxt = (w_qcnt_nxt >= qcnt_w'(3 * q_clks));
      end
      default: begin
        w_scl_nxt = 1'b1;
        w_rel_nxt = 1'b1;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_qcnt    <= '0;
      r_bcnt    <= 3'd0;
      r_ptr     <= 1'b0;
      r_gidx    <= 1'b0;
      r_rw      <= 1'b0;
      r_addr    <= 7'd0;
      r_wdata   <= 8'd0;
      r_shift   <= 8'd0;
      r_samp    <= 1'b0;
      r_done    <= 2'b00;
      r_rdata   <= 8'd0;
      r_ack_err <= 1'b0;
      r_busy    <= 1'b0;
      r_scl     <= 1'b1;
      r_sda_rel <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_qcnt    <= w_qcnt_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gidx    <= w_gidx_nxt;
      r_rw      <= w_rw_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_shift   <= w_shift_nxt;
      r_samp    <= w_samp_nxt;
      r_done    <= w_done_nxt;
      r_rdata   <= w_rdata_nxt;
      r_ack_err <= w_ack_err_nxt;
      r_busy    <= w_busy_nxt;
      r_scl     <= w_scl_nxt;
      r_sda_rel <= w_rel_nxt;
    end
  end

endmodule
